// File: rtl/apb_mem_responder.sv
// apb_mem_responder
//   APB completer that terminates transfers from an APB master and backs them
//   with a word-addressed register memory of DEPTH words. Each transfer gets a
//   programmable number of wait states (sampled at setup). Read data, ready and
//   slverr are registered. wren/rden pulse for one cycle after a committed
//   write / completed read, for observation by the memory-bus side.
//
//   Optional feature macro: APB_SLVERR_EN
//     defined   : addr >= DEPTH reports slverr with ready, suppresses the write
//                 (no memory update, no wren), returns rdata = 0; rden still pulses.
//     undefined : slverr tied low, addresses alias modulo DEPTH.
//
// Ports
//   clk         bus clock, rising edge
//   reset       asynchronous active-low reset
//   sel         PSEL
//   enable      PENABLE
//   write       PWRITE (1 = write)
//   addr        PADDR, word address
//   wdata       PWDATA
//   wait_cycles wait states for the next transfer, sampled at setup
//   rdata       PRDATA (registered)
//   ready       PREADY (registered)
//   slverr      PSLVERR (registered, meaningful only with ready)
//   wren        one-cycle pulse after a committed write
//   rden        one-cycle pulse after a completed read
module apb_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wait_cycles,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              slverr,
  output logic              wren,
  output logic              rden
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                slverr_q, slverr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                wren_q, wren_d;
  logic                rden_q, rden_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;

  // Address of the current access: in IDLE the setup edge has not latched it
  // yet, so the live bus address is used; afterwards the latched copy.
  logic [ADDR_W-1:0]   acc_addr;
  logic [IDX_W-1:0]    acc_idx;
  logic                acc_oor;
  logic                err_now;
  logic [DATA_W-1:0]   load_data;

  assign acc_addr = (state_q == S_IDLE) ? addr : addr_q;
  assign acc_idx  = acc_addr[IDX_W-1:0];
  // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
  assign acc_oor  = ({1'b0, acc_addr} >= (ADDR_W+1)'(DEPTH));

`ifdef APB_SLVERR_EN
  assign err_now = acc_oor;
`else
  logic unused_oor;
  assign unused_oor = acc_oor;
  assign err_now    = 1'b0;
`endif

  assign load_data = err_now ? '0 : mem_q[acc_idx];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ready_d  = ready_q;
    slverr_d = slverr_q;
    rdata_d  = rdata_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // enable without a setup phase is not a transfer; ignore it.
        if (sel && !enable) begin
          wr_d    = write;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = wait_cycles;
          if (wait_cycles == 4'd0) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            slverr_d = err_now;
            rdata_d  = load_data;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!sel) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
        end else if (enable) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            slverr_d = err_now;
            rdata_d  = load_data;
          end
        end
      end

      S_DONE: begin
        if (!sel) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
        end else if (enable) begin
          if (wr_q) begin
            if (!err_now) begin
              mem_we = 1'b1;
              wren_d = 1'b1;
            end
          end else begin
            rden_d = 1'b1;
          end
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign slverr = slverr_q;
  assign wren   = wren_q;
  assign rden   = rden_q;

endmodule

// File: doc/apb_mem_responder.md
# apb_mem_responder

APB completer that terminates transfers issued by the APB master and backs them with a local word-addressed register memory. Inserts a programmable number of wait states per transfer, returns read data and an optional error response, and emits one-cycle memory-strobe pulses for observation by the memory-bus side. Sits on the APB bus opposite the master, in place of a bare memory model.

## Interface
Parameters:
- DATA_W, 32, data width of pwdata/prdata and of each memory word
- ADDR_W, 8, APB address width (word address)
- DEPTH, 16, number of memory words; power of two, DEPTH ≤ 2^ADDR_W

Ports:
- clk  in  1  bus clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- sel  in  1  APB select (PSEL)
- enable  in  1  APB enable (PENABLE)
- write  in  1  1 = write, 0 = read (PWRITE)
- addr  in  ADDR_W  word address (PADDR)
- wdata  in  DATA_W  write data (PWDATA)
- wait_cycles  in  4  wait states for next transfer, sampled in setup phase
- rdata  out  DATA_W  read data (PRDATA), registered
- ready  out  1  transfer-complete (PREADY), registered
- slverr  out  1  error response (PSLVERR), registered, valid only with ready
- wren  out  1  one-cycle pulse, cycle after a committed write
- rden  out  1  one-cycle pulse, cycle after a completed read

## Operation
- Reset (reset = 0, async): state IDLE, ready = 0, slverr = 0, rdata = 0, wren = 0, rden = 0, counter = 0, all memory words = 0.
- States: IDLE, WAIT, DONE.
- IDLE: on edge with sel = 1, enable = 0 (setup): latch write, addr, wdata; cnt ← wait_cycles; if wait_cycles = 0 → DONE, ready ← 1; else → WAIT. enable = 1 while in IDLE: ignored.
- WAIT: each edge with sel = 1, enable = 1: cnt ← cnt − 1; if cnt = 1 → DONE, ready ← 1.
- DONE: ready = 1. On edge with sel = 1, enable = 1 (completion): write → mem[idx] ← latched wdata, wren ← 1 next cycle; read → rden ← 1 next cycle; ready ← 0, slverr ← 0, → IDLE.
- Read data: rdata ← mem[idx] on the edge entering DONE; holds until next DONE entry.
- Abort: sel = 0 in WAIT or DONE → IDLE, ready ← 0, no memory update, no strobe.
- idx = addr[log2(DEPTH)−1:0].
- Address/data latched at setup; changes on addr/wdata during access are ignored.
- Write and read to same word in consecutive transfers: read returns newly written value.

## Timing
- Wait states: exactly wait_cycles access cycles with ready = 0, then one access cycle with ready = 1. Total transfer = 2 + wait_cycles cycles.
- wait_cycles = 0: ready high in first access cycle (zero-wait APB).
- wait_cycles changes outside setup edge: no effect on current transfer.
- Back-to-back: setup may occur on the edge immediately after completion (IDLE sampled that edge).
- wren/rden high exactly one cycle, starting the cycle after completion edge.
- Reset asserted mid-transfer: immediate return to reset values; no partial write.

## Configuration
- APB_SLVERR_EN defined: addr ≥ DEPTH is out of range; slverr ← 1 together with ready; write suppressed (no memory update, no wren); rdata ← 0; rden still pulses. In-range transfers: slverr = 0.
- APB_SLVERR_EN undefined: slverr tied 0; out-of-range addresses alias via idx (modulo DEPTH).

## Test plan
- Zero-wait write addr 3 wdata 0xDEADBEEF, then read addr 3 -> ready high in first access cycle both times, rdata = 0xDEADBEEF, wren then rden single-cycle pulses.
- wait_cycles = 5, write addr 7 0x12345678 -> ready low 5 access cycles, high on 6th; read back with wait_cycles = 3 -> 3 low cycles, rdata = 0x12345678.
- wait_cycles = 1 read of unwritten addr 9 -> one wait state, rdata = 0, slverr = 0.
- Abort: setup write addr 2 0xAAAA5555, wait_cycles = 4, drop sel after 2 access cycles -> ready never high, no wren, read addr 2 returns 0.
- Out-of-range write addr 0x20 0xCAFEF00D (DEPTH 16) -> with APB_SLVERR_EN: slverr = 1 with ready, no wren, read addr 0 returns 0; without: slverr = 0, read addr 0 returns 0xCAFEF00D.
- Assert reset during WAIT after prior write to addr 1 -> all outputs 0 same cycle, memory cleared, next zero-wait read addr 1 returns 0.
